// File: rtl/spi_flash_reader.sv
// SPI flash READ (03h) engine: sends command and 24-bit address, then streams
// the returned bytes out as a valid-strobed byte stream. CS is active-high.
module spi_flash_reader #(
    parameter logic [7:0]  CMD        = 8'h03,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        abort,
    output logic        busy,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [4:0] GAP_LAST = 5'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [31:0] pre_sh;
    logic [7:0]  rx_sh;
    logic [8:0]  remain;
    logic        miso_q;
    logic        accept;
    logic        byte_done;
    logic        gap_done;

    assign byte_done = (cnt[2:0] == 3'd7);
    assign gap_done  = (cnt == GAP_LAST);
    // The last GAP clock also accepts, so back-to-back requests see exactly
    // GAP_CYCLES deselect clocks between transactions.
    assign accept    = req_valid && ((state == S_IDLE) || ((state == S_GAP) && gap_done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid) state_next = S_CMD;
            S_CMD: begin
                if (abort) state_next = S_GAP;
                else if (cnt == 5'd7) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (abort) state_next = S_GAP;
                else if (cnt == 5'd23) state_next = S_DATA;
            end
            S_DATA: begin
                if (abort) state_next = S_GAP;
                else if (byte_done && (remain == 9'd1)) state_next = S_GAP;
            end
            S_GAP: if (gap_done) state_next = accept ? S_CMD : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // MISO is captured on the rising SCLK edge (falling clk) where it is stable.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= spi_miso;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            pre_sh    <= '0;
            rx_sh     <= '0;
            remain    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (state != state_next) cnt <= '0;
            else                     cnt <= cnt + 5'd1;
            case (state)
                S_CMD, S_ADDR: pre_sh <= {pre_sh[30:0], 1'b0};
                S_DATA: begin
                    if (!abort) begin
                        rx_sh <= {rx_sh[6:0], miso_q};
                        if (byte_done) begin
                            out_valid <= 1'b1;
                            out_last  <= (remain == 9'd1);
                            out_data  <= {rx_sh[6:0], miso_q};
                            remain    <= remain - 9'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (accept) begin
                pre_sh <= {CMD, req_addr};
                rx_sh  <= '0;
                remain <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
            end
        end
    end

    assign req_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);
    assign spi_cs    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    assign spi_mosi  = ((state == S_CMD) || (state == S_ADDR)) ? pre_sh[31] : 1'b0;
    assign spi_sclk  = ~clk;

endmodule
